// File: rtl/max_sched_pkg.sv
// Shared types and default sizing for the max-search scheduler slice.
package max_sched_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_BURST_LEN = 20;
    localparam int DEF_CNT_W     = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/max_track_core.sv
// Running-maximum register: cleared at burst start, updated per accepted sample.
module max_track_core
    import max_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] max
);

    logic [WIDTH-1:0] max_r;

    // Unsigned running maximum; equal samples leave the stored value untouched.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            max_r <= {WIDTH{1'b0}};
        end else if (clear) begin
            max_r <= {WIDTH{1'b0}};
        end else if (en && (din >= max_r)) begin
            max_r <= din;
        end else begin
            max_r <= max_r;
        end
    end

    assign max = max_r;

endmodule

// File: rtl/max_search_scheduler.sv
// Two-requester round-robin scheduler sharing one running-max datapath per burst.
module max_search_scheduler
    import max_sched_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [1:0]       valid,
    input  logic [WIDTH-1:0] data_0,
    input  logic [WIDTH-1:0] data_1,
    output logic [1:0]       grant,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             result_id,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_r, state_nxt;
    logic [1:0]       grant_r, grant_nxt;
    logic             owner_r, owner_nxt;
    logic             ptr_r, ptr_nxt;
    logic [CNT_W-1:0] cnt_r, cnt_nxt;
    logic [WIDTH-1:0] result_r, result_nxt;
    logic             result_id_r, result_id_nxt;
    logic             result_valid_r, result_valid_nxt;
    logic             busy_r, busy_nxt;

    logic             winner_s;
    logic             start_s;
    logic             accept_s;
    logic [WIDTH-1:0] din_s;
    logic [WIDTH-1:0] max_s;

    // With both requesting the pointer decides, otherwise the lone requester wins.
    assign winner_s = (req == 2'b11) ? ptr_r : req[1];
    assign start_s  = (state_r == IDLE) && (req != 2'b00);
    assign din_s    = owner_r ? data_1 : data_0;
    assign accept_s = (state_r == RUN) && req[owner_r] && valid[owner_r];

    max_track_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clock (clock),
        .reset (reset),
        .clear (start_s),
        .en    (accept_s),
        .din   (din_s),
        .max   (max_s)
    );

    // Next-state and next-output logic; outputs are all registered below.
    always_comb begin
        state_nxt        = state_r;
        grant_nxt        = grant_r;
        owner_nxt        = owner_r;
        ptr_nxt          = ptr_r;
        cnt_nxt          = cnt_r;
        result_nxt       = result_r;
        result_id_nxt    = result_id_r;
        result_valid_nxt = 1'b0;
        busy_nxt         = busy_r;

        case (state_r)
            IDLE: begin
                if (start_s) begin
                    owner_nxt = winner_s;
                    grant_nxt = winner_s ? 2'b10 : 2'b01;
                    cnt_nxt   = CNT_LOAD;
                    busy_nxt  = 1'b1;
                    state_nxt = RUN;
                end else begin
                    grant_nxt = 2'b00;
                    busy_nxt  = 1'b0;
                end
            end
            RUN: begin
                if (!req[owner_r]) begin
                    // Abort: partial burst is dropped and the other side gets priority.
                    ptr_nxt   = ~owner_r;
                    grant_nxt = 2'b00;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else if (accept_s) begin
                    cnt_nxt = cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        // Last sample folds into the result the same cycle it is accepted.
                        result_nxt       = (din_s >= max_s) ? din_s : max_s;
                        result_id_nxt    = owner_r;
                        result_valid_nxt = 1'b1;
                        grant_nxt        = 2'b00;
                        state_nxt        = DONE;
                    end else begin
                        state_nxt = RUN;
                    end
                end else begin
                    state_nxt = RUN;
                end
            end
            DONE: begin
                ptr_nxt   = ~owner_r;
                grant_nxt = 2'b00;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                grant_nxt = 2'b00;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Arbiter, counter and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            grant_r        <= 2'b00;
            owner_r        <= 1'b0;
            ptr_r          <= 1'b0;
            cnt_r          <= {CNT_W{1'b0}};
            result_r       <= {WIDTH{1'b0}};
            result_id_r    <= 1'b0;
            result_valid_r <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            grant_r        <= grant_nxt;
            owner_r        <= owner_nxt;
            ptr_r          <= ptr_nxt;
            cnt_r          <= cnt_nxt;
            result_r       <= result_nxt;
            result_id_r    <= result_id_nxt;
            result_valid_r <= result_valid_nxt;
            busy_r         <= busy_nxt;
        end
    end

    assign grant        = grant_r;
    assign result       = result_r;
    assign result_id    = result_id_r;
    assign result_valid = result_valid_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_max_search_scheduler.sv
// Directed bench for max_search_scheduler with hand-computed expected values.
module tb_max_search_scheduler;

    logic       clock  = 1'b0;
    logic       reset  = 1'b0;
    logic [1:0] req    = 2'b00;
    logic [1:0] valid  = 2'b00;
    logic [7:0] data_0 = 8'h00;
    logic [7:0] data_1 = 8'h00;
    logic [1:0] grant;
    logic [7:0] result;
    logic       result_valid;
    logic       result_id;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    max_search_scheduler #(
        .WIDTH     (8),
        .BURST_LEN (20),
        .CNT_W     (5)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .valid        (valid),
        .data_0       (data_0),
        .data_1       (data_1),
        .grant        (grant),
        .result       (result),
        .result_valid (result_valid),
        .result_id    (result_id),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic feed(input int id, input logic [7:0] d, input int gap);
        for (int i = 0; i < gap; i++) tick();
        if (id == 0) data_0 = d; else data_1 = d;
        valid[id] = 1'b1;
        tick();
        valid[id] = 1'b0;
    endtask

    // Called right after the edge that accepted the last sample.
    task automatic expect_result(input string tag, input logic [7:0] r, input logic id);
        check_value({tag, "_rv"},    32'(result_valid), 32'd1);
        check_value({tag, "_res"},   32'(result),       32'(r));
        check_value({tag, "_id"},    32'(result_id),    32'(id));
        check_value({tag, "_gnt"},   32'(grant),        32'd0);
        tick();
        check_value({tag, "_rv_lo"}, 32'(result_valid), 32'd0);
        check_value({tag, "_hold"},  32'(result),       32'(r));
        check_value({tag, "_busy"},  32'(busy),         32'd0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check_value("rst_grant", 32'(grant),        32'd0);
        check_value("rst_res",   32'(result),       32'd0);
        check_value("rst_rv",    32'(result_valid), 32'd0);
        check_value("rst_id",    32'(result_id),    32'd0);
        check_value("rst_busy",  32'(busy),         32'd0);
        reset = 1'b1;
        tick();

        // Single requester 0, samples 1..20
        req = 2'b01;
        tick();
        check_value("t1_grant", 32'(grant), 32'd1);
        check_value("t1_busy",  32'(busy),  32'd1);
        for (int i = 1; i <= 19; i++) feed(0, 8'(i), 0);
        check_value("t1_rv_early", 32'(result_valid), 32'd0);
        feed(0, 8'd20, 0);
        expect_result("t1", 8'd20, 1'b0);
        req = 2'b00;
        tick();
        check_value("t1_idle_gnt", 32'(grant), 32'd0);

        // 0xFF mid-burst with valid gaps
        req = 2'b01;
        tick();
        check_value("t2_grant", 32'(grant), 32'd1);
        for (int i = 1; i <= 19; i++) feed(0, (i == 10) ? 8'hFF : 8'(i * 7), (i % 4 == 0) ? 2 : 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_value("t2_gap_rv",   32'(result_valid), 32'd0);
            check_value("t2_gap_busy", 32'(busy),         32'd1);
        end
        feed(0, 8'd3, 0);
        expect_result("t2", 8'hFF, 1'b0);
        req = 2'b00;
        tick();

        // Both requesting from reset; non-granted port carries 0xFF noise
        reset = 1'b0;
        tick();
        reset = 1'b1;
        req = 2'b11;
        tick();
        check_value("t3_gnt0", 32'(grant), 32'd1);
        valid[1] = 1'b1;
        data_1 = 8'hFF;
        for (int i = 1; i <= 20; i++) feed(0, 8'(50 - i), 0);
        valid[1] = 1'b0;
        expect_result("t3a", 8'd49, 1'b0);
        check_value("t3_gap_gnt", 32'(grant), 32'd0);
        tick();
        check_value("t3_gnt1", 32'(grant), 32'd2);
        valid[0] = 1'b1;
        data_0 = 8'hFF;
        for (int i = 1; i <= 20; i++) feed(1, 8'(i * 2), 0);
        valid[0] = 1'b0;
        expect_result("t3b", 8'd40, 1'b1);
        tick();
        check_value("t3_gnt0_again", 32'(grant), 32'd1);

        // Requester 0 drops req after 7 samples
        for (int i = 1; i <= 7; i++) feed(0, 8'(100 + i), 0);
        req = 2'b10;
        tick();
        check_value("t4_abort_gnt",  32'(grant),        32'd0);
        check_value("t4_abort_rv",   32'(result_valid), 32'd0);
        check_value("t4_abort_busy", 32'(busy),         32'd0);
        check_value("t4_abort_res",  32'(result),       32'd40);
        tick();
        check_value("t4_next_gnt", 32'(grant), 32'd2);
        check_value("t4_next_rv",  32'(result_valid), 32'd0);
        req = 2'b00;
        tick();
        check_value("t4_drop_gnt", 32'(grant), 32'd0);

        // Reset at sample 10, then an all-0x05 burst
        req = 2'b01;
        tick();
        for (int i = 1; i <= 10; i++) feed(0, 8'h30, 0);
        #2;
        reset = 1'b0;
        req = 2'b00;
        #1;
        check_value("t5_grant", 32'(grant),        32'd0);
        check_value("t5_res",   32'(result),       32'd0);
        check_value("t5_rv",    32'(result_valid), 32'd0);
        check_value("t5_id",    32'(result_id),    32'd0);
        check_value("t5_busy",  32'(busy),         32'd0);
        tick();
        tick();
        reset = 1'b1;
        req = 2'b01;
        tick();
        check_value("t5_regrant", 32'(grant), 32'd1);
        for (int i = 1; i <= 20; i++) feed(0, 8'h05, 0);
        expect_result("t5", 8'h05, 1'b0);
        req = 2'b00;
        tick();

        // All-zero burst
        req = 2'b01;
        tick();
        for (int i = 1; i <= 20; i++) feed(0, 8'h00, 0);
        expect_result("t6", 8'h00, 1'b0);
        req = 2'b00;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/max_search_scheduler.md
# max_search_scheduler

Shares a single running-maximum datapath between two requesters. Each requester asks for a search over a fixed-length burst of unsigned samples. A round-robin arbiter grants the datapath to one requester at a time, and a small FSM sequences the burst. It counts accepted samples and returns the maximum, tagged with the requester ID, as a one-cycle result pulse. It sits between the sample producers and downstream consumers of the per-burst maximum.

## Interface
- WIDTH, 8, sample and result width in bits
- BURST_LEN, 20, samples per search (≥1)
- CNT_W, 5, counter width; must satisfy 2^CNT_W > BURST_LEN

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req  in  2  per-requester search request (level, held for whole burst)
- valid  in  2  per-requester sample valid
- data_0  in  WIDTH  requester 0 sample
- data_1  in  WIDTH  requester 1 sample
- grant  out  2  one-hot datapath ownership (00 when idle)
- result  out  WIDTH  maximum of completed burst
- result_valid  out  1  one-cycle pulse, result/result_id valid
- result_id  out  1  requester that owns result
- busy  out  1  high in RUN and DONE

## Operation
- FSM states:
  - IDLE: grant=00. If any req bit is high, pick a winner. With one request, it wins. With both, the round-robin pointer decides.
    - Set grant, load counter=BURST_LEN, clear max to 0, go to RUN.
  - RUN: a sample is accepted on each edge where valid[g] & grant[g] for the granted g. Valid on the non-granted port is ignored.
    - Per accepted sample: max ← (data ≥ max) ? data : max (unsigned), counter ← counter−1.
    - When the accepted sample has counter==1, go to DONE.
    - If req[g] falls while in RUN, abort: go to IDLE, no result, pointer advances.
  - DONE: result_valid=1, result=max, result_id=g, grant=00.
    - Pointer ← other requester. Go to IDLE.
- Round-robin pointer: reset value favours requester 0. It is updated only on DONE or abort.
- Comparison is unsigned; ties keep the value (no observable change).
- result/result_id hold their last value until the next DONE; result_valid is a pulse only.
- Reset values: grant=00, result=0, result_valid=0, result_id=0, busy=0, state=IDLE, counter=0, max=0, pointer=0.
- Reset asserted mid-burst: immediate return to reset values; the partial burst is discarded and never reported.

## Timing
- req sampled high in IDLE at edge t: grant high after t. First sample can be accepted at edge t+1.
- Last (BURST_LEN-th) sample accepted at edge u: result_valid high during cycle after u (one-cycle latency), low after u+1.
- DONE→IDLE→next grant: the earliest next grant appears after edge u+2, a minimum 2-cycle gap between bursts.
- Gaps in valid stretch the burst; there is no timeout.
- req and valid for a requester are sampled only while it holds grant. A req raised during another's burst waits; it is not lost if held.
- Simultaneous req on both in IDLE: the pointer winner is granted. After its DONE, the other is granted if still requesting.

## Structure
- Package max_sched_pkg: state enum (IDLE, RUN, DONE), default WIDTH/BURST_LEN/CNT_W constants.
- Sub-module max_track_core: register plus compare.
  - Inputs: clock, reset, clear, en, din.
  - Output: max.
  - The scheduler owns the FSM, counter, arbiter and mux of data_0/data_1 into din.

## Test plan
- Single requester 0, BURST_LEN=20 samples 1..20 with 20 last → result=20, result_id=0, one result_valid pulse one cycle after the 20th accept.
- Samples with max 0xFF mid-burst and valid gaps inserted → result=0xFF. Counter counts only accepted samples, so the pulse follows the 20th valid.
- Both req high from reset → requester 0 granted first, requester 1 second. Then both high again → 0 granted (pointer alternates); valid on the non-granted port never affects result.
- req[0] dropped after 7 samples → no result_valid. grant goes to 00, then requester 1 (if requesting) is granted next. result retains the previous value.
- reset asserted at sample 10 of a burst → all outputs 0 immediately. A new burst of all-0x05 after release → result=0x05.
- All-zero burst → result=0x00 with result_valid pulse (ties handled, no hang).
